// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Core-side load/store bus of the memory access unit.
//   master : the core's memory stage (drives the request, receives response)
//   slave  : the memory access unit
// Request signals : cpu_valid, cpu_ready, cpu_we, cpu_funct3, cpu_addr,
//                   cpu_wdata  (transfer on cpu_valid & cpu_ready)
// Response signals: rsp_valid (one-cycle strobe), rsp_rdata, rsp_fault
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_fault;

  modport master (
    output cpu_valid, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  cpu_valid, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store front end for one port of the 32k x 32 data RAM wrapper.
// Accepts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW from the core, decodes faults,
// builds the word address, byte write enables and replicated store data,
// runs the RAM's one-shot request handshake and returns extended load data
// or a fault code.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   cpu             : core request/response bus (mem_access_unit_if.slave)
//   busy            : an access is in flight (state != IDLE)
//   ram_we          : byte write enables (0000 for loads, IDLE and RESP)
//   ram_addr        : RAM word address
//   ram_din         : RAM write data
//   ram_req         : one-cycle request pulse
//   ram_dout        : RAM read data, valid with ram_read_valid
//   ram_done        : RAM port idle/complete
//   ram_read_valid  : RAM read data strobe
//
// Fault codes: 00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int BYTE_ADDR_W = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_access_unit_if.slave       cpu,
  output logic                   busy,
  output logic [3:0]             ram_we,
  output logic [BYTE_ADDR_W-3:0] ram_addr,
  output logic [31:0]            ram_din,
  output logic                   ram_req,
  input  logic [31:0]            ram_dout,
  input  logic                   ram_done,
  input  logic                   ram_read_valid
);

  localparam int WORD_ADDR_W = BYTE_ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10,
    FAULT_FUNCT3   = 2'b11
  } faultT;

  stateT state, nextState;

  // Registered state of the access in flight.
  logic                   done_q;     // ram_done of the previous cycle
  logic                   seen_low;   // store: RAM has dropped done since the request
  logic [WORD_ADDR_W-1:0] addrQ;
  logic [1:0]             laneQ;
  logic [2:0]             funct3Q;
  logic                   weQ;
  logic [3:0]             weMaskQ;
  logic [31:0]            dinQ;
  logic [31:0]            rdataQ;
  faultT                  faultQ;

  // Decode of the presented request (meaningful only on accept).
  logic        accept;
  logic        illegal;
  logic        outOfRange;
  logic        misaligned;
  faultT       faultCode;
  logic [3:0]  storeMask;
  logic [31:0] storeData;

  // Lane extraction of returning read data.
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    storeMask  = 4'b1111;
    storeData  = cpu.cpu_wdata;

    if (cpu.cpu_we) begin
      illegal = (cpu.cpu_funct3 >= 3'b011);
    end else begin
      case (cpu.cpu_funct3)
        3'b011, 3'b110, 3'b111: illegal = 1'b1;
        default:                illegal = 1'b0;
      endcase
    end

    outOfRange = |cpu.cpu_addr[31:BYTE_ADDR_W];

    // funct3[1:0] is the access size for every legal encoding.
    case (cpu.cpu_funct3[1:0])
      2'b00: begin
        storeMask = 4'b0001 << cpu.cpu_addr[1:0];
        storeData = {4{cpu.cpu_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = cpu.cpu_addr[0];
        storeMask  = 4'b0011 << cpu.cpu_addr[1:0];
        storeData  = {2{cpu.cpu_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |cpu.cpu_addr[1:0];
      end
      default: ;
    endcase

    if (illegal)         faultCode = FAULT_FUNCT3;
    else if (outOfRange) faultCode = FAULT_RANGE;
    else if (misaligned) faultCode = FAULT_MISALIGN;
    else                 faultCode = FAULT_NONE;
  end

  // -------------------------------------------------------------------------
  // Load data extraction and extension
  // -------------------------------------------------------------------------
  always_comb begin
    byteSel = ram_dout[{laneQ, 3'b000} +: 8];
    halfSel = laneQ[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (funct3Q)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b100:  loadData = {24'd0, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b101:  loadData = {16'd0, halfSel};
      default: loadData = ram_dout;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    nextState     = state;
    // A lone done cycle is not enough: mid-read the RAM can pulse done for a
    // single cycle, so ready needs done in this and the previous cycle.
    cpu.cpu_ready = (state == IDLE) && ram_done && done_q;
    cpu.rsp_valid = 1'b0;
    cpu.rsp_rdata = '0;
    cpu.rsp_fault = FAULT_NONE;
    busy          = (state != IDLE);
    ram_we        = 4'b0000;
    ram_addr      = addrQ;
    ram_din       = dinQ;
    ram_req       = 1'b0;
    accept        = cpu.cpu_valid && cpu.cpu_ready;

    case (state)
      IDLE: begin
        if (accept) nextState = (faultCode == FAULT_NONE) ? ISSUE : RESP;
      end
      ISSUE: begin
        ram_req   = 1'b1;
        ram_we    = weMaskQ;
        nextState = WAIT;
      end
      WAIT: begin
        ram_we = weMaskQ;
        if (weQ) begin
          // Completion is done rising again after it was seen low.
          if (ram_done && seen_low) nextState = RESP;
        end else if (ram_read_valid) begin
          nextState = RESP;
        end
      end
      RESP: begin
        cpu.rsp_valid = 1'b1;
        cpu.rsp_rdata = rdataQ;
        cpu.rsp_fault = faultQ;
        nextState     = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: these are individual control/data registers, so all of them are
  // cleared by reset; outputs derived from them read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q   <= 1'b0;
      seen_low <= 1'b0;
      addrQ    <= '0;
      laneQ    <= 2'b00;
      funct3Q  <= 3'b000;
      weQ      <= 1'b0;
      weMaskQ  <= 4'b0000;
      dinQ     <= '0;
      rdataQ   <= '0;
      faultQ   <= FAULT_NONE;
    end else begin
      done_q <= ram_done;
      case (state)
        IDLE: begin
          if (accept) begin
            faultQ <= faultCode;
            rdataQ <= '0;
            if (faultCode == FAULT_NONE) begin
              addrQ   <= cpu.cpu_addr[BYTE_ADDR_W-1:2];
              laneQ   <= cpu.cpu_addr[1:0];
              funct3Q <= cpu.cpu_funct3;
              weQ     <= cpu.cpu_we;
              weMaskQ <= cpu.cpu_we ? storeMask : 4'b0000;
              dinQ    <= cpu.cpu_we ? storeData : 32'd0;
            end
          end
        end
        ISSUE: seen_low <= 1'b0;
        WAIT: begin
          if (weQ && !ram_done)         seen_low <= 1'b1;
          if (!weQ && ram_read_valid)   rdataQ   <= loadData;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [3:0]  ram_we;
  logic [14:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_req;
  logic [31:0] ram_dout;
  logic        ram_done;
  logic        ram_read_valid;

  mem_access_unit_if bus();

  mem_access_unit #(.BYTE_ADDR_W(17)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu            (bus),
    .busy           (busy),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_req        (ram_req),
    .ram_dout       (ram_dout),
    .ram_done       (ram_done),
    .ram_read_valid (ram_read_valid)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int nCompared = 0;
  int nMismatch = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // RAM port model: request -> done low for two cycles -> done high with
  // read data strobe in the third cycle; writes land at the end of it.
  // Not reset by rst, so an aborted access still completes on the RAM side.
  // ---------------------------------------------------------------------
  logic [31:0] ramMem [0:32767];
  int          cnt = 0;
  logic        pendRead = 1'b0;
  logic [14:0] pendAddr = '0;
  logic [3:0]  pendWe = '0;
  logic [31:0] pendDin = '0;
  logic        holdLow = 1'b0;

  initial for (int i = 0; i < 32768; i++) ramMem[i] = 32'd0;

  always @(posedge clk) begin
    if (ram_req) begin
      cnt      <= 3;
      pendAddr <= ram_addr;
      pendWe   <= ram_we;
      pendDin  <= ram_din;
      pendRead <= (ram_we == 4'b0000);
    end else if (cnt > 0) begin
      if (cnt == 1 && !pendRead)
        for (int b = 0; b < 4; b++)
          if (pendWe[b]) ramMem[pendAddr][8*b +: 8] <= pendDin[8*b +: 8];
      cnt <= cnt - 1;
    end
  end

  assign ram_done       = !holdLow && (cnt <= 1);
  assign ram_read_valid = !holdLow && (cnt == 1) && pendRead;
  assign ram_dout       = (cnt == 1) ? ramMem[pendAddr] : 32'hA5A5A5A5;

  // ---------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  fault;
  } expT;

  expT        sb[$];
  logic [7:0] refBytes [int];

  function automatic logic [7:0] refRead(input int a);
    return refBytes.exists(a) ? refBytes[a] : 8'h00;
  endfunction

  function automatic expT model(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd);
    expT         e;
    logic        legal;
    int          nBytes;
    logic [31:0] v;
    logic [31:0] mask;
    e.rdata = 32'd0;
    e.fault = 2'b00;
    legal   = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nBytes  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    if (!legal)                        e.fault = 2'b11;
    else if (addr >= 32'h0002_0000)    e.fault = 2'b10;
    else if ((addr % nBytes) != 0)     e.fault = 2'b01;
    if (e.fault == 2'b00) begin
      if (we) begin
        for (int i = 0; i < nBytes; i++) refBytes[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nBytes; i++) v[8*i +: 8] = refRead(int'(addr) + i);
        mask = (nBytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nBytes)) - 32'd1);
        if (!f3[2] && nBytes < 4 && v[8*nBytes-1]) v = v | ~mask;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Response monitor: every response pops one expectation.
  always @(negedge clk) begin
    expT e;
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_fault", {30'd0, bus.rsp_fault}, {30'd0, e.fault});
      end
    end
  end

  int acceptCount = 0;
  always @(negedge clk) if (bus.cpu_valid && bus.cpu_ready) acceptCount++;

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  logic [3:0]  lastWe;
  logic [14:0] lastAddr;
  logic [31:0] lastDin;

  task automatic runAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output int waits);
    expT e;
    int  lat;
    int  reqs;
    e = model(we, f3, addr, wd);
    sb.push_back(e);
    bus.cpu_we     = we;
    bus.cpu_funct3 = f3;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wd;
    bus.cpu_valid  = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!bus.cpu_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.cpu_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.cpu_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.cpu_valid = 1'b0;
    lat  = 0;
    reqs = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        lastWe   = ram_we;
        lastAddr = ram_addr;
        lastDin  = ram_din;
      end
      if (ram_req) reqs++;
      if (bus.rsp_valid) begin
        lat = c;
        break;
      end
    end
    check("latency", lat, (e.fault != 2'b00) ? 32'd1 : 32'd5);
    check("req_count", reqs, (e.fault != 2'b00) ? 32'd0 : 32'd1);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int   w;
    int   got;
    logic anyReady;
    logic we;
    logic [2:0] f3;
    logic [2:0] loadF3 [5];
    expT  e;
    loadF3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    bus.cpu_valid  = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_funct3 = 3'd0;
    bus.cpu_addr   = 32'd0;
    bus.cpu_wdata  = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_ready", bus.cpu_ready, 32'd0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata[28:0]}, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_ram_ctl", {ram_req, ram_we, ram_addr}, 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Word store then sub-word loads
    runAccess(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, w);
    check("sw_ram_addr", lastAddr, 32'h041);
    check("sw_ram_we", lastWe, 32'hF);
    check("sw_ram_din", lastDin, 32'hDEADBEEF);
    runAccess(1'b0, 3'b000, 32'h107, 32'd0, w);
    runAccess(1'b0, 3'b100, 32'h107, 32'd0, w);
    runAccess(1'b0, 3'b001, 32'h104, 32'd0, w);
    runAccess(1'b0, 3'b101, 32'h106, 32'd0, w);
    check("b2b_wait", w, 32'd0);

    // Sub-word stores
    runAccess(1'b1, 3'b000, 32'h105, 32'h00000012, w);
    check("sb_ram_we", lastWe, 32'b0010);
    check("sb_ram_din", lastDin, 32'h12121212);
    runAccess(1'b0, 3'b010, 32'h104, 32'd0, w);
    runAccess(1'b1, 3'b001, 32'h106, 32'h00005A5A, w);
    check("sh_ram_we", lastWe, 32'b1100);
    check("sh_ram_din", lastDin, 32'h5A5A5A5A);

    // Faults
    runAccess(1'b0, 3'b010, 32'h102, 32'd0, w);
    runAccess(1'b1, 3'b010, 32'h0002_0000, 32'h11111111, w);
    runAccess(1'b0, 3'b011, 32'h104, 32'd0, w);
    runAccess(1'b1, 3'b011, 32'h0002_0001, 32'd0, w);

    // Small random mix around 0x100
    for (int k = 0; k < 12; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 2)) : loadF3[$urandom_range(0, 4)];
      runAccess(we, f3, 32'h100 + 32'($urandom_range(0, 15)), $urandom, w);
    end
    runAccess(1'b0, 3'b010, 32'h104, 32'd0, w);

    // Reset in cycle 2 of a load
    bus.cpu_we     = 1'b0;
    bus.cpu_funct3 = 3'b010;
    bus.cpu_addr   = 32'h104;
    bus.cpu_valid  = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.cpu_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("abort_accept", bus.cpu_ready, 32'd1);
    @(posedge clk);
    #1 bus.cpu_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", busy, 32'd0);
    check("abort_ram_ctl", {ram_req, ram_we, ram_addr}, 32'd0);
    check("abort_ram_din", ram_din, 32'd0);
    check("abort_cpu", {bus.cpu_ready, bus.rsp_valid, bus.rsp_fault}, 32'd0);
    check("abort_rdata", bus.rsp_rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    runAccess(1'b0, 3'b010, 32'h104, 32'd0, w);
    check("post_rst_wait", w, 32'd2);

    // RAM holds done low before the first accept
    @(posedge clk);
    #1 holdLow = 1'b1;
    @(posedge clk);
    #1;
    e = model(1'b0, 3'b001, 32'h106, 32'd0);
    sb.push_back(e);
    bus.cpu_we     = 1'b0;
    bus.cpu_funct3 = 3'b001;
    bus.cpu_addr   = 32'h106;
    bus.cpu_valid  = 1'b1;
    acceptCount    = 0;
    anyReady       = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.cpu_ready) anyReady = 1'b1;
    end
    check("hold_ready_low", anyReady, 32'd0);
    @(posedge clk);
    #1 holdLow = 1'b0;
    @(negedge clk);
    check("ready_first_done", bus.cpu_ready, 32'd0);
    @(negedge clk);
    check("ready_second_done", bus.cpu_ready, 32'd1);
    got = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1;
        bus.cpu_valid = 1'b0;
        break;
      end
    end
    bus.cpu_valid = 1'b0;
    check("hold_rsp_seen", got, 32'd1);
    repeat (3) @(negedge clk);
    check("accept_once", acceptCount, 32'd1);

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
